// File: rtl/csr_pkg.sv
// Shared constants, CSR addresses and enums for the CSR access unit.
package csr_pkg;

  localparam int unsigned CSR_DW    = 32;
  localparam int unsigned CSR_ADDRW = 12;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // mstatus bit positions
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  // mcause for machine external interrupt
  localparam logic [31:0] CAUSE_MEXT = 32'h8000_000B;

  typedef enum logic [2:0] {
    F3_RW  = 3'b001,
    F3_RS  = 3'b010,
    F3_RC  = 3'b011,
    F3_RWI = 3'b101,
    F3_RSI = 3'b110,
    F3_RCI = 3'b111
  } funct3_e;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD      = 4'd1,
    S_WR      = 4'd2,
    S_T_CHK   = 4'd3,
    S_T_STAT  = 4'd4,
    S_T_EPC   = 4'd5,
    S_T_CAUSE = 4'd6,
    S_T_VEC   = 4'd7,
    S_M_RD    = 4'd8,
    S_M_WR    = 4'd9,
    S_M_EPC   = 4'd10
  } state_e;

endpackage

// File: rtl/csr_rmw_alu.sv
// Zicsr read-modify-write value and write qualifier.
module csr_rmw_alu
  import csr_pkg::*;
#(
  parameter int unsigned DW = CSR_DW
) (
  input  logic [2:0]    funct3_i,
  input  logic [DW-1:0] old_i,
  input  logic [DW-1:0] src_i,
  output logic [DW-1:0] wdata_o,
  output logic          write_en_o
);

  // Set/clear forms skip the write when the mask is zero; unknown funct3 never writes
  always_comb begin
    wdata_o    = '0;
    write_en_o = 1'b0;
    case (funct3_i)
      F3_RW, F3_RWI: begin
        wdata_o    = src_i;
        write_en_o = 1'b1;
      end
      F3_RS, F3_RSI: begin
        wdata_o    = old_i | src_i;
        write_en_o = (src_i != '0);
      end
      F3_RC, F3_RCI: begin
        wdata_o    = old_i & ~src_i;
        write_en_o = (src_i != '0);
      end
      default: begin
        wdata_o    = '0;
        write_en_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// CSR port initiator: Zicsr read-modify-write, interrupt entry and MRET sequencing.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int unsigned DW    = CSR_DW,
  parameter int unsigned ADDRW = CSR_ADDRW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_mret_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [ADDRW-1:0] req_addr_i,
  input  logic [DW-1:0]    req_src_i,
  input  logic [4:0]       req_rs1_i,
  input  logic [4:0]       req_rd_i,
  input  logic             intr_i,
  input  logic [DW-1:0]    pc_i,
  output logic [ADDRW-1:0] csr_addr_o,
  output logic             csr_re_o,
  output logic             csr_we_o,
  output logic [DW-1:0]    csr_wdata_o,
  input  logic [DW-1:0]    csr_rdata_i,
  output logic             rsp_valid_o,
  output logic [4:0]       rsp_rd_o,
  output logic             rsp_we_o,
  output logic [DW-1:0]    rsp_data_o,
  output logic             redirect_o,
  output logic [DW-1:0]    redirect_pc_o
);

  state_e           state_q, state_d;
  logic [2:0]       f3_q, f3_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [DW-1:0]    src_q, src_d;
  logic [4:0]       rd_q, rd_d;
  logic [DW-1:0]    old_q, old_d;
  logic [DW-1:0]    pc_q, pc_d;

  logic [ADDRW-1:0] addr_c;
  logic             re_c, we_c, rsp_valid_c, rsp_we_c, redirect_c;
  logic [DW-1:0]    wdata_c, rsp_data_c, redirect_pc_c;
  logic [4:0]       rsp_rd_c;
  logic             rw_form_c;
  logic [DW-1:0]    alu_wdata;
  logic             alu_we;

  csr_rmw_alu #(.DW(DW)) u_rmw_alu (
    .funct3_i   (f3_q),
    .old_i      (old_q),
    .src_i      (src_q),
    .wdata_o    (alu_wdata),
    .write_en_o (alu_we)
  );

  // State and latched request registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      addr_q  <= '0;
      src_q   <= '0;
      rd_q    <= '0;
      old_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      rd_q    <= rd_d;
      old_q   <= old_d;
      pc_q    <= pc_d;
    end
  end

  // Next state and port decode from state plus latched registers
  always_comb begin
    state_d       = state_q;
    f3_d          = f3_q;
    addr_d        = addr_q;
    src_d         = src_q;
    rd_d          = rd_q;
    old_d         = old_q;
    pc_d          = pc_q;
    addr_c        = '0;
    re_c          = 1'b0;
    we_c          = 1'b0;
    wdata_c       = '0;
    rsp_valid_c   = 1'b0;
    rsp_rd_c      = '0;
    rsp_we_c      = 1'b0;
    rsp_data_c    = '0;
    redirect_c    = 1'b0;
    redirect_pc_c = '0;
    rw_form_c     = (f3_q[1:0] == 2'b01);

    case (state_q)
      S_IDLE: begin
        if (intr_i) begin
          pc_d    = pc_i;
          state_d = S_T_CHK;
        end else if (req_valid_i) begin
          f3_d    = req_funct3_i;
          addr_d  = req_addr_i;
          src_d   = req_funct3_i[2] ? DW'(req_rs1_i) : req_src_i;
          rd_d    = req_rd_i;
          state_d = req_mret_i ? S_M_RD : S_RD;
        end
      end
      S_RD: begin
        addr_c  = addr_q;
        re_c    = !(rw_form_c && (rd_q == 5'd0));
        old_d   = re_c ? csr_rdata_i : '0;
        state_d = S_WR;
      end
      S_WR: begin
        addr_c      = addr_q;
        we_c        = alu_we;
        wdata_c     = alu_we ? alu_wdata : '0;
        rsp_valid_c = 1'b1;
        rsp_rd_c    = rd_q;
        rsp_we_c    = (rd_q != 5'd0);
        rsp_data_c  = old_q;
        state_d     = S_IDLE;
      end
      S_T_CHK: begin
        addr_c = ADDRW'(CSR_MSTATUS);
        re_c   = 1'b1;
        if (csr_rdata_i[MSTATUS_MIE]) begin
          old_d   = csr_rdata_i;
          state_d = S_T_STAT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T_STAT: begin
        addr_c                = ADDRW'(CSR_MSTATUS);
        we_c                  = 1'b1;
        wdata_c               = old_q;
        wdata_c[MSTATUS_MPIE] = old_q[MSTATUS_MIE];
        wdata_c[MSTATUS_MIE]  = 1'b0;
        state_d               = S_T_EPC;
      end
      S_T_EPC: begin
        addr_c  = ADDRW'(CSR_MEPC);
        we_c    = 1'b1;
        wdata_c = pc_q;
        state_d = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        addr_c  = ADDRW'(CSR_MCAUSE);
        we_c    = 1'b1;
        wdata_c = DW'(CAUSE_MEXT);
        state_d = S_T_VEC;
      end
      S_T_VEC: begin
        addr_c        = ADDRW'(CSR_MTVEC);
        re_c          = 1'b1;
        redirect_c    = 1'b1;
        redirect_pc_c = {csr_rdata_i[DW-1:2], 2'b00};
        state_d       = S_IDLE;
      end
      S_M_RD: begin
        addr_c  = ADDRW'(CSR_MSTATUS);
        re_c    = 1'b1;
        old_d   = csr_rdata_i;
        state_d = S_M_WR;
      end
      S_M_WR: begin
        addr_c                = ADDRW'(CSR_MSTATUS);
        we_c                  = 1'b1;
        wdata_c               = old_q;
        wdata_c[MSTATUS_MIE]  = old_q[MSTATUS_MPIE];
        wdata_c[MSTATUS_MPIE] = 1'b1;
        state_d               = S_M_EPC;
      end
      S_M_EPC: begin
        addr_c        = ADDRW'(CSR_MEPC);
        re_c          = 1'b1;
        redirect_c    = 1'b1;
        redirect_pc_c = csr_rdata_i;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset silences the port immediately so an aborted sequence never commits a write
  assign req_ready_o   = (state_q == S_IDLE) && !intr_i;
  assign csr_addr_o    = rst_i ? '0 : addr_c;
  assign csr_re_o      = re_c & ~rst_i;
  assign csr_we_o      = we_c & ~rst_i;
  assign csr_wdata_o   = rst_i ? '0 : wdata_c;
  assign rsp_valid_o   = rsp_valid_c & ~rst_i;
  assign rsp_rd_o      = rst_i ? '0 : rsp_rd_c;
  assign rsp_we_o      = rsp_we_c & ~rst_i;
  assign rsp_data_o    = rst_i ? '0 : rsp_data_c;
  assign redirect_o    = redirect_c & ~rst_i;
  assign redirect_pc_o = rst_i ? '0 : redirect_pc_c;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: directed table, hand sequences and randomized model check.
module tb_csr_access_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_mret_i;
  logic [2:0]  req_funct3_i;
  logic [11:0] req_addr_i;
  logic [31:0] req_src_i;
  logic [4:0]  req_rs1_i, req_rd_i;
  logic        intr_i;
  logic [31:0] pc_i;
  logic [11:0] csr_addr_o;
  logic        csr_re_o, csr_we_o;
  logic [31:0] csr_wdata_o, csr_rdata_i;
  logic        rsp_valid_o, rsp_we_o;
  logic [4:0]  rsp_rd_o;
  logic [31:0] rsp_data_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  always #5 clk = ~clk;

  csr_access_unit dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_mret_i(req_mret_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_src_i(req_src_i),
    .req_rs1_i(req_rs1_i), .req_rd_i(req_rd_i), .intr_i(intr_i), .pc_i(pc_i),
    .csr_addr_o(csr_addr_o), .csr_re_o(csr_re_o), .csr_we_o(csr_we_o),
    .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rd_o(rsp_rd_o), .rsp_we_o(rsp_we_o),
    .rsp_data_o(rsp_data_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  // CSR file: combinational read, write on enable; preload port for the bench
  logic [31:0] mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;
  assign csr_rdata_i = mem[csr_addr_o];
  always @(posedge clk) begin
    if (csr_we_o) mem[csr_addr_o] <= csr_wdata_o;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] model [int];

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, fld, got, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One expected cycle of a trap/MRET/idle sequence; returns at posedge+1
  task automatic cyc(input string nm, input bit e_re, input bit e_we, input logic [11:0] e_addr,
                     input logic [31:0] e_wdata, input bit e_redir, input logic [31:0] e_rpc, input bit e_rdy);
    @(negedge clk);
    chk(nm, "re", 32'(csr_re_o), 32'(e_re));
    chk(nm, "we", 32'(csr_we_o), 32'(e_we));
    if (e_re || e_we) chk(nm, "addr", 32'(csr_addr_o), 32'(e_addr));
    if (e_we) chk(nm, "wdata", csr_wdata_o, e_wdata);
    chk(nm, "redirect", 32'(redirect_o), 32'(e_redir));
    if (e_redir) chk(nm, "redirect_pc", redirect_pc_o, e_rpc);
    chk(nm, "ready", 32'(req_ready_o), 32'(e_rdy));
    chk(nm, "rsp_valid", 32'(rsp_valid_o), 32'd0);
    @(posedge clk); #1;
  endtask

  // Full CSR instruction from acceptance to ready again
  task automatic do_op(input string nm, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] src,
                       input logic [4:0] rs1, input logic [4:0] rd, input bit e_re, input bit e_we,
                       input logic [31:0] e_wdata, input logic [31:0] e_old);
    req_valid_i = 1'b1; req_mret_i = 1'b0; req_funct3_i = f3; req_addr_i = a;
    req_src_i = src; req_rs1_i = rs1; req_rd_i = rd;
    @(negedge clk);
    chk(nm, "accept_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_funct3_i = 3'($urandom); req_addr_i = 12'($urandom);
    req_src_i = $urandom; req_rs1_i = 5'($urandom); req_rd_i = 5'($urandom);
    @(negedge clk);
    chk(nm, "rd.re", 32'(csr_re_o), 32'(e_re));
    chk(nm, "rd.we", 32'(csr_we_o), 32'd0);
    if (e_re) chk(nm, "rd.addr", 32'(csr_addr_o), 32'(a));
    chk(nm, "rd.rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk(nm, "rd.ready", 32'(req_ready_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk(nm, "wr.re", 32'(csr_re_o), 32'd0);
    chk(nm, "wr.we", 32'(csr_we_o), 32'(e_we));
    if (e_we) begin
      chk(nm, "wr.addr", 32'(csr_addr_o), 32'(a));
      chk(nm, "wr.wdata", csr_wdata_o, e_wdata);
    end
    chk(nm, "rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk(nm, "rsp_rd", 32'(rsp_rd_o), 32'(rd));
    chk(nm, "rsp_we", 32'(rsp_we_o), 32'(rd != 5'd0));
    chk(nm, "rsp_data", rsp_data_o, e_old);
    @(posedge clk); #1;
    @(negedge clk);
    chk(nm, "post.rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk(nm, "post.ready", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
  endtask

  // Interrupt entry; a CSR request is offered alongside to show intr wins
  task automatic do_trap(input string nm, input logic [31:0] pc, input bit taken,
                         input logic [31:0] e_stat, input logic [31:0] e_vec);
    intr_i = 1'b1; pc_i = pc;
    req_valid_i = 1'b1; req_mret_i = 1'b0; req_funct3_i = F3_RW; req_addr_i = CSR_MIE;
    req_src_i = $urandom; req_rd_i = 5'd1;
    @(negedge clk);
    chk(nm, "entry_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk); #1;
    intr_i = 1'b0; req_valid_i = 1'b0; pc_i = $urandom;
    cyc({nm, ".chk"}, 1, 0, CSR_MSTATUS, 0, 0, 0, !taken ? 1'b0 : 1'b0);
    if (taken) begin
      cyc({nm, ".stat"},  0, 1, CSR_MSTATUS, e_stat,     0, 0,     0);
      cyc({nm, ".epc"},   0, 1, CSR_MEPC,    pc,         0, 0,     0);
      cyc({nm, ".cause"}, 0, 1, CSR_MCAUSE,  CAUSE_MEXT, 0, 0,     0);
      cyc({nm, ".vec"},   1, 0, CSR_MTVEC,   0,          1, e_vec, 0);
    end
    cyc({nm, ".idle"}, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_mret(input string nm, input logic [31:0] e_stat, input logic [31:0] e_pc);
    req_valid_i = 1'b1; req_mret_i = 1'b1; req_funct3_i = 3'($urandom);
    req_addr_i = 12'($urandom); req_src_i = $urandom; req_rd_i = 5'($urandom);
    @(negedge clk);
    chk(nm, "accept_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_mret_i = 1'b0;
    cyc({nm, ".rd"},   1, 0, CSR_MSTATUS, 0,      0, 0,    0);
    cyc({nm, ".wr"},   0, 1, CSR_MSTATUS, e_stat, 0, 0,    0);
    cyc({nm, ".epc"},  1, 0, CSR_MEPC,    0,      1, e_pc, 0);
    cyc({nm, ".idle"}, 0, 0, 0,           0,      0, 0,    1);
  endtask

  // Reference rules for a Zicsr op on a CSR currently holding cur
  function automatic void ref_csr(input logic [2:0] f3, input logic [31:0] cur, input logic [31:0] src_reg,
                                  input logic [4:0] rs1, input logic [4:0] rd, output bit reads,
                                  output bit writes, output logic [31:0] wval, output logic [31:0] old);
    logic [31:0] src;
    src    = f3[2] ? {27'd0, rs1} : src_reg;
    reads  = !(f3[1:0] == 2'b01 && rd == 5'd0);
    old    = reads ? cur : 32'd0;
    writes = (f3[1:0] == 2'b01) || (src != 32'd0);
    case (f3[1:0])
      2'b01:   wval = src;
      2'b10:   wval = old | src;
      default: wval = old & ~src;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] src;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [31:0] init;
    bit          e_re;
    bit          e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_old;
  } vec_t;

  vec_t tbl [7];
  logic [11:0] raddrs [6];

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_mret_i = 1'b0; req_funct3_i = '0; req_addr_i = '0;
    req_src_i = '0; req_rs1_i = '0; req_rd_i = '0; intr_i = 1'b0; pc_i = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    tbl[0] = '{F3_RW,  12'h305, 32'h8000_0100, 5'd0,  5'd5, 32'h0,   1, 1, 32'h8000_0100, 32'h0};
    tbl[1] = '{F3_RS,  12'h300, 32'h0,         5'd0,  5'd7, 32'h8,   1, 0, 32'h0,         32'h8};
    tbl[2] = '{F3_RCI, 12'h304, 32'hFFFF_FFFF, 5'd1,  5'd3, 32'h801, 1, 1, 32'h800,       32'h801};
    tbl[3] = '{F3_RW,  12'h340, 32'h1234,      5'd0,  5'd0, 32'h55,  0, 1, 32'h1234,      32'h0};
    tbl[4] = '{F3_RSI, 12'h340, 32'h0,         5'd31, 5'd1, 32'h100, 1, 1, 32'h11F,       32'h100};
    tbl[5] = '{F3_RC,  12'h341, 32'hF0,        5'd0,  5'd2, 32'hFF,  1, 1, 32'h0F,        32'hFF};
    tbl[6] = '{F3_RWI, 12'h342, 32'hFFFF_FFFF, 5'd31, 5'd0, 32'h9,   0, 1, 32'h1F,        32'h0};
    raddrs = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, 12'h340};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", "we_in_reset", 32'(csr_we_o), 32'd0);
    chk("reset", "rsp_in_reset", 32'(rsp_valid_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    cyc("reset_idle", 0, 0, 0, 0, 0, 0, 1);
    chk("reset_idle", "addr", 32'(csr_addr_o), 32'd0);
    chk("reset_idle", "rsp_data", rsp_data_o, 32'd0);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      preload(tbl[i].addr, tbl[i].init);
      do_op($sformatf("tbl%0d", i), tbl[i].f3, tbl[i].addr, tbl[i].src, tbl[i].rs1, tbl[i].rd,
            tbl[i].e_re, tbl[i].e_we, tbl[i].e_wdata, tbl[i].e_old);
      chk($sformatf("tbl%0d", i), "csr_after", mem[tbl[i].addr],
          tbl[i].e_we ? tbl[i].e_wdata : tbl[i].init);
    end

    // Interrupt taken
    preload(CSR_MSTATUS, 32'h8); preload(CSR_MTVEC, 32'h101);
    preload(CSR_MEPC, 32'h0); preload(CSR_MCAUSE, 32'h0);
    do_trap("trap", 32'h40, 1, 32'h80, 32'h100);
    chk("trap", "mstatus", mem[CSR_MSTATUS], 32'h80);
    chk("trap", "mepc", mem[CSR_MEPC], 32'h40);
    chk("trap", "mcause", mem[CSR_MCAUSE], 32'h8000_000B);

    // Interrupt masked
    preload(CSR_MSTATUS, 32'h0); preload(CSR_MEPC, 32'h77);
    do_trap("trap_masked", 32'h50, 0, 0, 0);
    chk("trap_masked", "mstatus", mem[CSR_MSTATUS], 32'h0);
    chk("trap_masked", "mepc", mem[CSR_MEPC], 32'h77);

    // MRET
    preload(CSR_MSTATUS, 32'h80); preload(CSR_MEPC, 32'h44);
    do_mret("mret", 32'h88, 32'h44);
    chk("mret", "mstatus", mem[CSR_MSTATUS], 32'h88);

    // Reset in the middle of trap entry
    preload(CSR_MSTATUS, 32'h8); preload(CSR_MEPC, 32'hDEAD);
    preload(CSR_MCAUSE, 32'h1234); preload(CSR_MTVEC, 32'h200);
    intr_i = 1'b1; pc_i = 32'h80;
    @(posedge clk); #1;
    intr_i = 1'b0;
    cyc("rst_mid.chk",  1, 0, CSR_MSTATUS, 0,     0, 0, 0);
    cyc("rst_mid.stat", 0, 1, CSR_MSTATUS, 32'h80, 0, 0, 0);
    rst_i = 1'b1;
    @(negedge clk);
    chk("rst_mid", "we", 32'(csr_we_o), 32'd0);
    chk("rst_mid", "re", 32'(csr_re_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    cyc("rst_mid.idle", 0, 0, 0, 0, 0, 0, 1);
    chk("rst_mid", "mepc", mem[CSR_MEPC], 32'hDEAD);
    chk("rst_mid", "mcause", mem[CSR_MCAUSE], 32'h1234);
    preload(12'h340, 32'h5);
    do_op("rst_mid.next", F3_RS, 12'h340, 32'h30, 5'd0, 5'd9, 1, 1, 32'h35, 32'h5);

    // Randomized against the reference model
    foreach (raddrs[k]) begin
      model[int'(raddrs[k])] = $urandom;
      preload(raddrs[k], model[int'(raddrs[k])]);
    end
    for (int it = 0; it < 150; it++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        logic [31:0] ms, pcv, ns;
        bit tk;
        ms  = model[int'(CSR_MSTATUS)];
        pcv = $urandom & 32'hFFFF_FFFC;
        tk  = ms[3];
        ns  = (ms & ~32'h88) | (tk ? 32'h80 : 32'h0);
        do_trap($sformatf("rnd%0d.trap", it), pcv, tk, ns, model[int'(CSR_MTVEC)] & ~32'h3);
        if (tk) begin
          model[int'(CSR_MSTATUS)] = ns;
          model[int'(CSR_MEPC)]    = pcv;
          model[int'(CSR_MCAUSE)]  = 32'h8000_000B;
        end
      end else if (sel == 1) begin
        logic [31:0] ms, ns;
        ms = model[int'(CSR_MSTATUS)];
        ns = (ms & ~32'h8) | (ms[7] ? 32'h8 : 32'h0) | 32'h80;
        do_mret($sformatf("rnd%0d.mret", it), ns, model[int'(CSR_MEPC)]);
        model[int'(CSR_MSTATUS)] = ns;
      end else begin
        logic [2:0]  f3;
        logic [11:0] a;
        logic [31:0] src, wv, old;
        logic [4:0]  rs1, rd;
        bit rds, wrs;
        logic [2:0] f3s [6];
        f3s = '{F3_RW, F3_RS, F3_RC, F3_RWI, F3_RSI, F3_RCI};
        f3  = f3s[$urandom_range(0, 5)];
        a   = raddrs[$urandom_range(0, 5)];
        src = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        ref_csr(f3, model[int'(a)], src, rs1, rd, rds, wrs, wv, old);
        do_op($sformatf("rnd%0d.op", it), f3, a, src, rs1, rd, rds, wrs, wv, old);
        if (wrs) model[int'(a)] = wv;
      end
      foreach (raddrs[k])
        chk($sformatf("rnd%0d", it), $sformatf("csr%03h", raddrs[k]), mem[raddrs[k]], model[int'(raddrs[k])]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
